// File: rtl/ff_calc_core.sv
// Stack-calculator evaluation engine: two-stack shunting-yard over operand/operator tokens.
// One reduce decision per cycle; registered ready/equals pulses and a sticky error flag.
module ff_calc_core #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_en,
  input  logic [31:0] data_in,
  output logic        calc_ready,
  output logic        is_equal,
  output logic [31:0] calc_answer,
  output logic        error,
  output logic        busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
  localparam logic [3:0] C_ADD = 4'd10;
  localparam logic [3:0] C_SUB = 4'd11;
  localparam logic [3:0] C_MUL = 4'd12;
  localparam logic [3:0] C_DIV = 4'd13;
  localparam logic [3:0] C_EQ  = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_REDUCE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] opnd_q [DEPTH];
  logic [DATA_W-1:0] opnd_d [DEPTH];
  logic [3:0]        op_q   [DEPTH];
  logic [3:0]        op_d   [DEPTH];
  logic [PTR_W-1:0]  nsp_q, nsp_d, osp_q, osp_d;
  logic [3:0]        tok_q, tok_d;
  logic              calc_ready_q, calc_ready_d;
  logic              is_equal_q, is_equal_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] answer_q, answer_d;

  logic [IDX_W-1:0]  ntop_idx, nsec_idx, otop_idx;
  logic [3:0]        op_top;
  logic [DATA_W-1:0] opnd_a, opnd_b, alu_res;
  logic              div_zero, code_ok, reduce_now;

  function automatic logic [1:0] prec(input logic [3:0] c);
    return (c == C_MUL || c == C_DIV) ? 2'd2 : 2'd1;
  endfunction

  assign ntop_idx   = IDX_W'(nsp_q - PTR_W'(1));
  assign nsec_idx   = IDX_W'(nsp_q - PTR_W'(2));
  assign otop_idx   = IDX_W'(osp_q - PTR_W'(1));
  assign op_top     = op_q[otop_idx];
  assign opnd_b     = opnd_q[ntop_idx];
  assign opnd_a     = opnd_q[nsec_idx];
  assign code_ok    = (data_in[3:0] >= C_ADD) && (data_in[3:0] <= C_EQ);
  assign reduce_now = (state_q == S_REDUCE) && (osp_q != '0) &&
                      ((tok_q == C_EQ) || (prec(op_top) >= prec(tok_q)));

  // Divide by -1 is a negate so INT_MIN / -1 wraps back to INT_MIN.
  always_comb begin
    alu_res  = '0;
    div_zero = 1'b0;
    case (op_top)
      C_ADD: alu_res = opnd_a + opnd_b;
      C_SUB: alu_res = opnd_a - opnd_b;
      C_MUL: alu_res = opnd_a * opnd_b;
      C_DIV: begin
        if (opnd_b == '0) begin
          div_zero = 1'b1;
        end else if (opnd_b == '1) begin
          alu_res = DATA_W'(0) - opnd_a;
        end else begin
          alu_res = DATA_W'($signed(opnd_a) / $signed(opnd_b));
        end
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (write_en && data_in[31] && code_ok) state_d = S_REDUCE;
      S_REDUCE: if (!reduce_now) state_d = (tok_q == C_EQ) ? S_DONE : S_IDLE;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Stack updates and registered outputs; errors never suppress the ready pulse.
  always_comb begin
    opnd_d       = opnd_q;
    op_d         = op_q;
    nsp_d        = nsp_q;
    osp_d        = osp_q;
    tok_d        = tok_q;
    calc_ready_d = 1'b0;
    is_equal_d   = 1'b0;
    answer_d     = answer_q;
    error_d      = error_q;
    busy_d       = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (write_en) begin
          if (!data_in[31]) begin
            calc_ready_d = 1'b1;
            if (nsp_q == FULL) begin
              error_d = 1'b1;
            end else begin
              opnd_d[IDX_W'(nsp_q)] = data_in;
              nsp_d = nsp_q + PTR_W'(1);
            end
          end else if (code_ok) begin
            tok_d = data_in[3:0];
          end else begin
            calc_ready_d = 1'b1;
            error_d      = 1'b1;
          end
        end
      end
      S_REDUCE: begin
        if (reduce_now) begin
          osp_d = osp_q - PTR_W'(1);
          if (nsp_q < PTR_W'(2)) begin
            opnd_d[0] = '0;
            nsp_d     = PTR_W'(1);
            error_d   = 1'b1;
          end else begin
            opnd_d[nsec_idx] = alu_res;
            nsp_d            = nsp_q - PTR_W'(1);
            if (div_zero) error_d = 1'b1;
          end
        end else if (tok_q != C_EQ) begin
          calc_ready_d = 1'b1;
          if (osp_q == FULL) begin
            error_d = 1'b1;
          end else begin
            op_d[IDX_W'(osp_q)] = tok_q;
            osp_d = osp_q + PTR_W'(1);
          end
        end else begin
          calc_ready_d = 1'b1;
          is_equal_d   = 1'b1;
          answer_d     = (nsp_q != '0) ? opnd_b : '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      nsp_q        <= '0;
      osp_q        <= '0;
      tok_q        <= '0;
      calc_ready_q <= 1'b0;
      is_equal_q   <= 1'b0;
      answer_q     <= '0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      nsp_q        <= nsp_d;
      osp_q        <= osp_d;
      tok_q        <= tok_d;
      calc_ready_q <= calc_ready_d;
      is_equal_q   <= is_equal_d;
      answer_q     <= answer_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  // Stack storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clock) begin
    opnd_q <= opnd_d;
    op_q   <= op_d;
  end

  assign calc_ready  = calc_ready_q;
  assign is_equal    = is_equal_q;
  assign calc_answer = answer_q;
  assign error       = error_q;
  assign busy        = busy_q;

endmodule
